// File: rtl/memory_bus_pkg.sv
// Shared types and constants for the memory bus bridge and its machine timer.
package memory_bus_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        WAIT    = 2'd2,
        RESPOND = 2'd3
    } bus_state_e;

    typedef enum logic {
        CMD_READ  = 1'b0,
        CMD_WRITE = 1'b1
    } bus_cmd_e;

    localparam logic [4:0] OFF_MSIP        = 5'h00;
    localparam logic [4:0] OFF_RSVD        = 5'h04;
    localparam logic [4:0] OFF_MTIMECMP_LO = 5'h08;
    localparam logic [4:0] OFF_MTIMECMP_HI = 5'h0C;
    localparam logic [4:0] OFF_MTIME_LO    = 5'h10;
    localparam logic [4:0] OFF_MTIME_HI    = 5'h14;
    localparam logic [31:0] TIMER_SPAN     = 32'h0000_0018;

    function automatic logic [31:0] apply_mask(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [31:0] mask);
        return (old_val & ~mask) | (new_val & mask);
    endfunction

endpackage

// File: rtl/memory_bus_mtimer.sv
// Machine timer: mtime/mtimecmp/msip registers, tick prescaler and interrupt compare.
module mtimer
    import memory_bus_pkg::*;
#(
    parameter int TICK_DIVIDER = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_en,
    input  logic [4:0]  wr_offset,
    input  logic [31:0] wr_data,
    input  logic [31:0] wr_mask,
    input  logic [4:0]  rd_offset,
    output logic [31:0] rd_data,
    output logic        timer_interrupt,
    output logic        software_interrupt
);

    localparam int PW = (TICK_DIVIDER > 1) ? $clog2(TICK_DIVIDER) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIVIDER - 1);

    logic [PW-1:0] presc_q, presc_d;
    logic [63:0]   mtime_q, mtime_d;
    logic [63:0]   mtimecmp_q, mtimecmp_d;
    logic          msip_q, msip_d;
    logic          tirq_q, tirq_d;
    logic          tick;
    logic [4:0]    wr_word;
    logic [4:0]    rd_word;

    assign wr_word = {wr_offset[4:2], 2'b00};
    assign rd_word = {rd_offset[4:2], 2'b00};

    always_comb begin
        tick       = (presc_q == PRESC_LAST);
        presc_d    = tick ? '0 : presc_q + PW'(1);
        mtime_d    = tick ? mtime_q + 64'd1 : mtime_q;
        mtimecmp_d = mtimecmp_q;
        msip_d     = msip_q;
        tirq_d     = (mtime_q >= mtimecmp_q);
        // A core write to mtime replaces any increment due in the same cycle.
        if (wr_en) begin
            case (wr_word)
                OFF_MSIP:        msip_d = (msip_q & ~wr_mask[0]) | (wr_data[0] & wr_mask[0]);
                OFF_MTIMECMP_LO: mtimecmp_d[31:0]  = apply_mask(mtimecmp_q[31:0], wr_data, wr_mask);
                OFF_MTIMECMP_HI: mtimecmp_d[63:32] = apply_mask(mtimecmp_q[63:32], wr_data, wr_mask);
                OFF_MTIME_LO:    mtime_d = {mtime_q[63:32], apply_mask(mtime_q[31:0], wr_data, wr_mask)};
                OFF_MTIME_HI:    mtime_d = {apply_mask(mtime_q[63:32], wr_data, wr_mask), mtime_q[31:0]};
                default:         ;
            endcase
        end
    end

    always_comb begin
        rd_data = '0;
        case (rd_word)
            OFF_MSIP:        rd_data = {31'b0, msip_q};
            OFF_RSVD:        rd_data = '0;
            OFF_MTIMECMP_LO: rd_data = mtimecmp_q[31:0];
            OFF_MTIMECMP_HI: rd_data = mtimecmp_q[63:32];
            OFF_MTIME_LO:    rd_data = mtime_q[31:0];
            OFF_MTIME_HI:    rd_data = mtime_q[63:32];
            default:         rd_data = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            presc_q    <= '0;
            mtime_q    <= '0;
            mtimecmp_q <= '1;
            msip_q     <= 1'b0;
            tirq_q     <= 1'b0;
        end else begin
            presc_q    <= presc_d;
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            msip_q     <= msip_d;
            tirq_q     <= tirq_d;
        end
    end

    assign timer_interrupt    = tirq_q;
    assign software_interrupt = msip_q;

endmodule

// File: rtl/memory_bus.sv
// Core-side memory bridge: decodes each request to RAM, machine timer or unmapped space.
//   state   | meaning
//   IDLE    | ready for a request; accept latches command/address/data/mask
//   ACCESS  | one-cycle RAM strobe
//   WAIT    | RAM latency countdown; read data captured on the final cycle
//   RESPOND | one-cycle completion (memory_valid, bus_error if unmapped)
module memory_bus
    import memory_bus_pkg::*;
#(
    parameter int          RAM_WORDS    = 16384,
    parameter int          RAM_LATENCY  = 1,
    parameter logic [31:0] TIMER_BASE   = 32'h0200_0000,
    parameter int          TICK_DIVIDER = 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         memory_enable,
    input  logic                         memory_command,
    input  logic [31:0]                  read_memory_address,
    input  logic [31:0]                  write_memory_address,
    input  logic [31:0]                  write_memory_data,
    input  logic [31:0]                  write_memory_mask,
    output logic                         memory_ready,
    output logic                         memory_valid,
    output logic [31:0]                  read_memory_data,
    output logic                         ram_enable,
    output logic                         ram_write,
    output logic [$clog2(RAM_WORDS)-1:0] ram_address,
    output logic [31:0]                  ram_write_data,
    output logic [31:0]                  ram_write_mask,
    input  logic [31:0]                  ram_read_data,
    output logic                         timer_interrupt,
    output logic                         software_interrupt,
    output logic                         bus_error
);

    localparam int AW = $clog2(RAM_WORDS);
    localparam int CW = (RAM_LATENCY > 1) ? $clog2(RAM_LATENCY) : 1;
    localparam logic [CW-1:0] WAIT_LOAD   = CW'(RAM_LATENCY - 1);
    localparam logic [31:0]   RAM_WORDS_W = 32'(RAM_WORDS);

    bus_state_e    state_q, state_d;
    logic          ready_q, ready_d;
    logic          valid_q, valid_d;
    logic          ram_en_q, ram_en_d;
    logic          ram_wr_q, ram_wr_d;
    logic          bus_err_q, bus_err_d;
    logic          cmd_q, cmd_d;
    logic [31:0]   rdata_q, rdata_d;
    logic [AW-1:0] ram_addr_q, ram_addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [31:0]   wmask_q, wmask_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic [31:0] req_addr;
    logic [31:0] timer_off;
    logic        ram_hit;
    logic        timer_hit;
    logic        accept;
    logic        timer_wr_en;
    logic [31:0] timer_rd_data;

    assign req_addr  = (memory_command == CMD_WRITE) ? write_memory_address : read_memory_address;
    assign ram_hit   = ({2'b00, req_addr[31:2]} < RAM_WORDS_W);
    assign timer_off = req_addr - TIMER_BASE;
    // The offset compare alone would wrap for addresses below the base.
    assign timer_hit = !ram_hit && (req_addr >= TIMER_BASE) && (timer_off < TIMER_SPAN);
    assign accept    = memory_enable && ready_q;
    assign timer_wr_en = accept && timer_hit && (memory_command == CMD_WRITE);

    mtimer #(
        .TICK_DIVIDER(TICK_DIVIDER)
    ) u_mtimer (
        .clk                (clk),
        .reset              (reset),
        .wr_en              (timer_wr_en),
        .wr_offset          (timer_off[4:0]),
        .wr_data            (write_memory_data),
        .wr_mask            (write_memory_mask),
        .rd_offset          (timer_off[4:0]),
        .rd_data            (timer_rd_data),
        .timer_interrupt    (timer_interrupt),
        .software_interrupt (software_interrupt)
    );

    always_comb begin
        state_d    = state_q;
        ready_d    = ready_q;
        valid_d    = valid_q;
        ram_en_d   = ram_en_q;
        ram_wr_d   = ram_wr_q;
        bus_err_d  = bus_err_q;
        cmd_d      = cmd_q;
        rdata_d    = rdata_q;
        ram_addr_d = ram_addr_q;
        wdata_d    = wdata_q;
        wmask_d    = wmask_q;
        cnt_d      = cnt_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    cmd_d      = memory_command;
                    ram_addr_d = req_addr[AW+1:2];
                    wdata_d    = write_memory_data;
                    wmask_d    = write_memory_mask;
                    ready_d    = 1'b0;
                    if (ram_hit) begin
                        state_d  = ACCESS;
                        ram_en_d = 1'b1;
                        ram_wr_d = memory_command;
                    end else begin
                        state_d = RESPOND;
                        valid_d = 1'b1;
                        if (timer_hit) begin
                            if (memory_command == CMD_READ) rdata_d = timer_rd_data;
                        end else begin
                            bus_err_d = 1'b1;
                            if (memory_command == CMD_READ) rdata_d = '0;
                        end
                    end
                end
            end
            ACCESS: begin
                state_d  = WAIT;
                ram_en_d = 1'b0;
                ram_wr_d = 1'b0;
                cnt_d    = WAIT_LOAD;
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = RESPOND;
                    valid_d = 1'b1;
                    if (cmd_q == CMD_READ) rdata_d = ram_read_data;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            RESPOND: begin
                state_d   = IDLE;
                valid_d   = 1'b0;
                bus_err_d = 1'b0;
                ready_d   = 1'b1;
            end
            default: begin
                state_d = IDLE;
                ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            ready_q    <= 1'b1;
            valid_q    <= 1'b0;
            ram_en_q   <= 1'b0;
            ram_wr_q   <= 1'b0;
            bus_err_q  <= 1'b0;
            cmd_q      <= 1'b0;
            rdata_q    <= '0;
            ram_addr_q <= '0;
            wdata_q    <= '0;
            wmask_q    <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            ready_q    <= ready_d;
            valid_q    <= valid_d;
            ram_en_q   <= ram_en_d;
            ram_wr_q   <= ram_wr_d;
            bus_err_q  <= bus_err_d;
            cmd_q      <= cmd_d;
            rdata_q    <= rdata_d;
            ram_addr_q <= ram_addr_d;
            wdata_q    <= wdata_d;
            wmask_q    <= wmask_d;
            cnt_q      <= cnt_d;
        end
    end

    assign memory_ready     = ready_q;
    assign memory_valid     = valid_q;
    assign read_memory_data = rdata_q;
    assign ram_enable       = ram_en_q;
    assign ram_write        = ram_wr_q;
    assign ram_address      = ram_addr_q;
    assign ram_write_data   = wdata_q;
    assign ram_write_mask   = wmask_q;
    assign bus_error        = bus_err_q;

endmodule
